// File: rtl/avg_pool_pkg.sv
// Shared types and helper constants for the average-pooling read controller.
// The optional watchdog is selected in avg_pool_ctrl by AVG_POOL_CTRL_WATCHDOG_EN.
package avg_pool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        BUFFER,
        SET_ADDR,
        WAIT,
        UPDATE,
        WRITE,
        FINISH
    } state_e;

    // Lane count used when the instantiating module does not override it.
    localparam int DEFAULT_LANES = 9;

    // Number of lane groups needed to sweep one channel.
    function automatic int lane_groups(input int depth, input int lanes);
        return (depth + lanes - 1) / lanes;
    endfunction

    // Width of the group offset register (always at least one bit).
    function automatic int offset_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/avg_pool_addr_gen.sv
// Combinational lane address and mask generation for one read group.
// Lane k reads base+offset+k while that word lies inside the channel;
// lanes past the end of the channel are masked and drive address 0.
module avg_pool_addr_gen
    import avg_pool_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LANES  = DEFAULT_LANES,
    parameter int DEPTH  = 4096,
    parameter int OFF_W  = offset_width(DEPTH)
) (
    input  logic [ADDR_W-1:0]       i_base,
    input  logic [OFF_W-1:0]        i_offset,
    output logic [LANES*ADDR_W-1:0] o_addr,
    output logic [LANES-1:0]        o_mask
);

    // Per-lane address and in-range mask.
    always_comb begin
        o_addr = '0;
        o_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            if (int'(i_offset) + k < DEPTH) begin
                o_mask[k]                  = 1'b1;
                o_addr[k*ADDR_W +: ADDR_W] = i_base + ADDR_W'(i_offset) + ADDR_W'(k);
            end
        end
    end

endmodule

// File: rtl/avg_pool_ctrl.sv
// Average-pooling read controller: sweeps CHANNELS channels of DEPTH words in
// groups of LANES parallel reads, clearing the accumulator before each channel
// and pulsing a result write after it.
// Define AVG_POOL_CTRL_WATCHDOG_EN to abort a stalled RAM read after WDOG_CYC
// WAIT cycles with a sticky o_error.
module avg_pool_ctrl
    import avg_pool_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int LANES    = DEFAULT_LANES,
    parameter int DEPTH    = 4096,
    parameter int CHANNELS = 4,
    parameter int WDOG_CYC = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_validRam,
    output logic [LANES*ADDR_W-1:0] o_addrRead,
    output logic [LANES-1:0]        o_laneMask,
    output logic                    o_startRam,
    output logic                    o_resetAverage,
    output logic                    o_writeEnable,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] o_channel,
    output logic                    o_busy,
    output logic                    o_finish,
    output logic                    o_error
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OFF_W = offset_width(DEPTH);

    // Addresses are never wrapped, so the whole sweep must fit the address space.
    if (longint'(CHANNELS) * longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_addr_range
        $error("avg_pool_ctrl: CHANNELS*DEPTH exceeds 2**ADDR_W");
    end
    if (WDOG_CYC < 1) begin : g_wdog_range
        $error("avg_pool_ctrl: WDOG_CYC must be at least 1");
    end

    state_e                  state_q, state_d;
    logic [OFF_W-1:0]        offset_q;
    logic [CH_W-1:0]         chan_q;
    logic                    active_q;
    logic                    start_ram_q;
    logic                    reset_avg_q;
    logic                    write_en_q;
    logic                    busy_q;
    logic                    finish_q;
    logic                    last_group;
    logic                    last_chan;
    logic [ADDR_W-1:0]       base;
    logic [LANES*ADDR_W-1:0] lane_addr;
    logic [LANES-1:0]        lane_mask;

`ifdef AVG_POOL_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_q;
    logic            err_q;
    logic            wdog_expire;

    // This WAIT cycle is the WDOG_CYC-th in a row without a RAM response.
    assign wdog_expire = (int'(wdog_q) >= WDOG_CYC - 1);
    assign o_error     = err_q;
`else
    assign o_error     = 1'b0;
`endif

    assign last_group = (int'(offset_q) + LANES >= DEPTH);
    assign last_chan  = (int'(chan_q) == CHANNELS - 1);
    assign base       = ADDR_W'(int'(chan_q) * DEPTH);

    avg_pool_addr_gen #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .OFF_W  (OFF_W)
    ) u_addr_gen (
        .i_base   (base),
        .i_offset (offset_q),
        .o_addr   (lane_addr),
        .o_mask   (lane_mask)
    );

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (i_start) state_d = CLEAR;
            CLEAR:    state_d = BUFFER;
            BUFFER:   state_d = SET_ADDR;
            SET_ADDR: state_d = WAIT;
            WAIT: begin
                if (i_validRam) state_d = UPDATE;
`ifdef AVG_POOL_CTRL_WATCHDOG_EN
                else if (wdog_expire) state_d = FINISH;
`endif
            end
            UPDATE:   state_d = last_group ? WRITE : SET_ADDR;
            WRITE:    state_d = last_chan ? FINISH : CLEAR;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, sweep counters and registered outputs decoded from the next state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            chan_q      <= '0;
            active_q    <= 1'b0;
            start_ram_q <= 1'b0;
            reset_avg_q <= 1'b1;
            write_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
`ifdef AVG_POOL_CTRL_WATCHDOG_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            active_q    <= (state_d == SET_ADDR) || (state_d == WAIT) || (state_d == UPDATE);
            start_ram_q <= (state_d == SET_ADDR);
            reset_avg_q <= (state_d != CLEAR);
            write_en_q  <= (state_d == WRITE);
            busy_q      <= (state_d != IDLE);
            finish_q    <= (state_d == FINISH);

            case (state_q)
                UPDATE: offset_q <= last_group ? '0 : offset_q + OFF_W'(LANES);
                WRITE:  if (!last_chan) chan_q <= chan_q + 1'b1;
                FINISH: begin
                    offset_q <= '0;
                    chan_q   <= '0;
                end
                default: ;
            endcase

`ifdef AVG_POOL_CTRL_WATCHDOG_EN
            wdog_q <= ((state_q == WAIT) && (state_d == WAIT)) ? wdog_q + 1'b1 : '0;
            if ((state_q == IDLE) && i_start)
                err_q <= 1'b0;
            else if ((state_q == WAIT) && (state_d == FINISH))
                err_q <= 1'b1;
`endif
        end
    end

    assign o_addrRead     = active_q ? lane_addr : '0;
    assign o_laneMask     = active_q ? lane_mask : '0;
    assign o_startRam     = start_ram_q;
    assign o_resetAverage = reset_avg_q;
    assign o_writeEnable  = write_en_q;
    assign o_channel      = chan_q;
    assign o_busy         = busy_q;
    assign o_finish       = finish_q;

endmodule

// File: tb/tb_avg_pool_ctrl.sv
// Randomized self-checking bench for avg_pool_ctrl. Every launched group is
// compared against a model that enumerates (channel, group) pairs arithmetically.
// The watchdog scenario is compiled only with AVG_POOL_CTRL_WATCHDOG_EN.
module tb_avg_pool_ctrl;

    localparam int AW   = 14;
    localparam int LN   = 9;
    localparam int DP   = 4096;
    localparam int CH   = 4;
    localparam int WD   = 255;
    localparam int NGRP = (DP + LN - 1) / LN;

    logic            i_clk;
    logic            i_reset;
    logic            i_start;
    logic            i_validRam;
    logic [LN*AW-1:0] o_addrRead;
    logic [LN-1:0]    o_laneMask;
    logic            o_startRam;
    logic            o_resetAverage;
    logic            o_writeEnable;
    logic [1:0]      o_channel;
    logic            o_busy;
    logic            o_finish;
    logic            o_error;

    int checks;
    int errors;
    int m_ch, m_grp, m_start, m_we, m_fin, m_clr;

    avg_pool_ctrl #(
        .ADDR_W   (AW),
        .LANES    (LN),
        .DEPTH    (DP),
        .CHANNELS (CH),
        .WDOG_CYC (WD)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_validRam     (i_validRam),
        .o_addrRead     (o_addrRead),
        .o_laneMask     (o_laneMask),
        .o_startRam     (o_startRam),
        .o_resetAverage (o_resetAverage),
        .o_writeEnable  (o_writeEnable),
        .o_channel      (o_channel),
        .o_busy         (o_busy),
        .o_finish       (o_finish),
        .o_error        (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        m_ch    = 0;
        m_grp   = 0;
        m_start = 0;
        m_we    = 0;
        m_fin   = 0;
        m_clr   = 0;
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_busy"},   128'(o_busy),         128'(0));
        check({tag, "_start"},  128'(o_startRam),     128'(0));
        check({tag, "_we"},     128'(o_writeEnable),  128'(0));
        check({tag, "_finish"}, 128'(o_finish),       128'(0));
        check({tag, "_error"},  128'(o_error),        128'(0));
        check({tag, "_rstavg"}, 128'(o_resetAverage), 128'(1));
        check({tag, "_addr"},   128'(o_addrRead),     128'(0));
        check({tag, "_mask"},   128'(o_laneMask),     128'(0));
        check({tag, "_chan"},   128'(o_channel),      128'(0));
    endtask

    // Observe one cycle: every read launch is checked against the model's next group.
    task automatic sample();
        logic [LN*AW-1:0] ea;
        logic [LN-1:0]    em;
        int               off;
        if (o_startRam) begin
            off = m_grp * LN;
            ea  = '0;
            em  = '0;
            for (int k = 0; k < LN; k++) begin
                if (off + k < DP) begin
                    em[k]          = 1'b1;
                    ea[k*AW +: AW] = AW'(m_ch * DP + off + k);
                end
            end
            check("grp_chan", 128'(o_channel),  128'(m_ch));
            check("grp_addr", 128'(o_addrRead), 128'(ea));
            check("grp_mask", 128'(o_laneMask), 128'(em));
            if (m_ch == 0 && off == 4095) begin
                check("tail_mask",   128'(o_laneMask),              128'(9'b000000001));
                check("tail_lane0",  128'(o_addrRead[AW-1:0]),      128'(4095));
                check("tail_lane18", 128'(o_addrRead[LN*AW-1:AW]),  128'(0));
            end
            if (m_ch == 2 && off == 0) begin
                check("ch2_chan", 128'(o_channel), 128'(2));
                for (int k = 0; k < LN; k++)
                    check("ch2_lane", 128'(o_addrRead[k*AW +: AW]), 128'(8192 + k));
            end
            m_start++;
            m_grp++;
            if (m_grp == NGRP) begin
                m_grp = 0;
                m_ch++;
            end
        end
        if (o_writeEnable)   m_we++;
        if (o_finish)        m_fin++;
        if (!o_resetAverage) m_clr++;
    endtask

    // One complete run from IDLE; optionally random RAM latency and stray i_start pulses.
    task automatic run_full(input bit rnd, input bit poke, input string tag);
        int cyc;
        reset_model();
        i_validRam = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        i_start    = 1'b1;
        cyc        = 0;
        do begin
            @(negedge i_clk);
            sample();
            i_start    = poke && o_busy && ($urandom_range(0, 3) == 0);
            i_validRam = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end while (m_fin == 0 && cyc < 30000);
        i_start = 1'b0;
        check({tag, "_done"}, 128'(m_fin), 128'(1));
        repeat (3) begin
            @(negedge i_clk);
            sample();
        end
        check({tag, "_startRam"}, 128'(m_start), 128'(CH * NGRP));
        check({tag, "_writes"},   128'(m_we),    128'(CH));
        check({tag, "_finish"},   128'(m_fin),   128'(1));
        check({tag, "_clears"},   128'(m_clr),   128'(CH));
        check({tag, "_idle"},     128'(o_busy),  128'(0));
        check({tag, "_error"},    128'(o_error), 128'(0));
    endtask

    initial begin
        int cyc;
        checks     = 0;
        errors     = 0;
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_validRam = 1'b0;
        reset_model();
        repeat (3) @(negedge i_clk);
        check_rst("reset");
        i_reset = 1'b0;
        @(negedge i_clk);
        check_rst("post_reset");

        // Default sweep with the RAM always ready.
        run_full(1'b0, 1'b0, "run_tied");

        // Random RAM latency with i_start pulses while busy.
        run_full(1'b1, 1'b1, "run_rand");

        // Reset while channel 1 waits on the RAM.
        reset_model();
        i_validRam = 1'b1;
        i_start    = 1'b1;
        cyc        = 0;
        do begin
            @(negedge i_clk);
            sample();
            i_start = 1'b0;
            cyc++;
        end while (!(o_startRam && o_channel == 2'd1) && cyc < 5000);
        check("mid_reach_ch1", 128'(o_channel), 128'(1));
        i_validRam = 1'b0;
        @(negedge i_clk);
        check("mid_busy", 128'(o_busy), 128'(1));
        #2 i_reset = 1'b1;
        #1 check_rst("mid_async");
        @(negedge i_clk);
        check_rst("mid_held");
        i_reset = 1'b0;
        @(negedge i_clk);
        check_rst("mid_after");
        run_full(1'b1, 1'b0, "run_restart");

`ifdef AVG_POOL_CTRL_WATCHDOG_EN
        // RAM never answers: the watchdog must abort the run.
        reset_model();
        i_validRam = 1'b0;
        i_start    = 1'b1;
        cyc        = 0;
        do begin
            @(negedge i_clk);
            sample();
            i_start = 1'b0;
            cyc++;
        end while (!o_startRam && cyc < 100);
        cyc = 0;
        do begin
            @(negedge i_clk);
            sample();
            cyc++;
        end while (!o_finish && cyc < 1000);
        check("wdog_cycles", 128'(cyc),      128'(WD + 1));
        check("wdog_finish", 128'(o_finish), 128'(1));
        check("wdog_error",  128'(o_error),  128'(1));
        @(negedge i_clk);
        check("wdog_sticky", 128'(o_error), 128'(1));
        check("wdog_idle",   128'(o_busy),  128'(0));
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("wdog_clear", 128'(o_error), 128'(0));
        check("wdog_busy",  128'(o_busy),  128'(1));
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
